fsm_seq_10010: RTL and testbench

FSM_SEQ_10010 -- requirements
Module: fsm_seq_10010

---
 rtl/fsm_seq_10010_pkg.sv | 27 ++
 rtl/fsm_seq_10010_mealy.sv | 45 ++++
 rtl/fsm_seq_10010_moore.sv | 46 ++++
 rtl/fsm_seq_10010.sv | 33 +++
 tb/tb_fsm_seq_10010.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fsm_seq_10010_pkg.sv
// rtl/fsm_seq_10010_pkg.sv - shared state encodings and pattern constant for the 10010 detector
// Contents: SEQ_PATTERN, mealy_state_t (codes 0..4), moore_state_t (codes 0..5).
package fsm_seq_10010_pkg;

    // Pattern to detect, first-received bit in the MSB.
    localparam logic [4:0] SEQ_PATTERN = 5'b10010;

    // Each state name is the longest pattern prefix seen so far.
    typedef enum logic [2:0] {
        M_IDLE = 3'd0,
        M_1    = 3'd1,
        M_10   = 3'd2,
        M_100  = 3'd3,
        M_1001 = 3'd4
    } mealy_state_t;

    // The Moore machine needs one extra state to hold the hit for a cycle.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_100  = 3'd3,
        S_1001 = 3'd4,
        S_HIT  = 3'd5
    } moore_state_t;

endpackage

// File: rtl/fsm_seq_10010_mealy.sv
// rtl/fsm_seq_10010_mealy.sv - Mealy detector for serial pattern 10010
// Ports: clk, rst_n (async active-low), x (serial bit), z (hit on the final 0, same cycle).
module fsm_seq_10010_mealy
    import fsm_seq_10010_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    output logic z
);

    mealy_state_t state;
    mealy_state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= M_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = M_IDLE;
        case (state)
            M_IDLE:  state_next = x ? M_1 : M_IDLE;
            M_1:     state_next = x ? M_1 : M_10;
            M_10:    state_next = x ? M_1 : M_100;
            M_100:   state_next = x ? M_1001 : M_IDLE;
            // After a hit, the trailing "10" is reusable as a new prefix when overlapping.
            M_1001:  state_next = x ? M_1 : ((OVERLAP != 0) ? M_10 : M_IDLE);
            default: state_next = M_IDLE;
        endcase
    end

    always_comb begin
        z = 1'b0;
        if (state == M_1001 && !x) begin
            z = 1'b1;
        end
    end

endmodule

// File: rtl/fsm_seq_10010_moore.sv
// rtl/fsm_seq_10010_moore.sv - Moore detector for serial pattern 10010
// Ports: clk, rst_n (async active-low), x (serial bit), z (high for one cycle after the final 0).
module fsm_seq_10010_moore
    import fsm_seq_10010_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    output logic z
);

    moore_state_t state;
    moore_state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:  state_next = x ? S_1 : S_IDLE;
            S_1:     state_next = x ? S_1 : S_10;
            S_10:    state_next = x ? S_1 : S_100;
            S_100:   state_next = x ? S_1001 : S_IDLE;
            S_1001:  state_next = x ? S_1 : S_HIT;
            // S_HIT already holds "10"; one more 0 makes the "100" prefix of the next hit.
            S_HIT:   state_next = x ? S_1 : ((OVERLAP != 0) ? S_100 : S_IDLE);
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        z = 1'b0;
        if (state == S_HIT) begin
            z = 1'b1;
        end
    end

endmodule

// File: rtl/fsm_seq_10010.sv
// rtl/fsm_seq_10010.sv - serial 10010 detector with Mealy and Moore flags
// Ports: clk, rst_n (async active-low), x (serial bit), z_mealy (same-cycle hit), z_moore (registered hit).
module fsm_seq_10010
    import fsm_seq_10010_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    output logic z_mealy,
    output logic z_moore
);

    fsm_seq_10010_mealy #(
        .OVERLAP(OVERLAP)
    ) u_mealy (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .z     (z_mealy)
    );

    fsm_seq_10010_moore #(
        .OVERLAP(OVERLAP)
    ) u_moore (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .z     (z_moore)
    );

endmodule

// File: tb/tb_fsm_seq_10010.sv
// tb/tb_fsm_seq_10010.sv - directed self-checking bench for fsm_seq_10010
module tb_fsm_seq_10010;
    import fsm_seq_10010_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic x = 1'b0;
    logic z_mealy1, z_moore1;
    logic z_mealy0, z_moore0;

    int n_checks = 0;
    int n_pass = 0;

    // Reference: 5-bit history compare; non-overlap variant clears history on a hit.
    logic [4:0] h1, h0;
    logic       mq1, mq0;
    int cnt_m1, cnt_q1, cnt_m0, cnt_q0;
    int cyc, first_m1, last_m1;
    string scen;

    always #5 clk = ~clk;

    fsm_seq_10010 #(.OVERLAP(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (x),
        .z_mealy (z_mealy1),
        .z_moore (z_moore1)
    );

    fsm_seq_10010 #(.OVERLAP(0)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (x),
        .z_mealy (z_mealy0),
        .z_moore (z_moore0)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        h1 = 5'd0; h0 = 5'd0; mq1 = 1'b0; mq0 = 1'b0;
        cnt_m1 = 0; cnt_q1 = 0; cnt_m0 = 0; cnt_q0 = 0;
        cyc = 0; first_m1 = -1; last_m1 = -1;
    endtask

    task automatic drive_bit(input logic b, output logic sm, output logic sq);
        logic e1, e0;
        @(negedge clk);
        x = b;
        #1;
        e1 = ({h1[3:0], b} == SEQ_PATTERN);
        e0 = ({h0[3:0], b} == SEQ_PATTERN);
        check({scen, " z_mealy ov1"}, 8'(z_mealy1), 8'(e1));
        check({scen, " z_moore ov1"}, 8'(z_moore1), 8'(mq1));
        check({scen, " z_mealy ov0"}, 8'(z_mealy0), 8'(e0));
        check({scen, " z_moore ov0"}, 8'(z_moore0), 8'(mq0));
        sm = z_mealy1;
        sq = z_moore1;
        if (z_mealy1) begin
            cnt_m1++;
            if (first_m1 < 0) first_m1 = cyc;
            last_m1 = cyc;
        end
        if (z_moore1) cnt_q1++;
        if (z_mealy0) cnt_m0++;
        if (z_moore0) cnt_q0++;
        @(posedge clk);
        h1 = {h1[3:0], b};
        mq1 = e1;
        h0 = e0 ? 5'd0 : {h0[3:0], b};
        mq0 = e0;
        cyc++;
    endtask

    task automatic drive_seq(input logic [31:0] bits, input int n);
        logic sm, sq;
        for (int i = n - 1; i >= 0; i--) begin
            drive_bit(bits[i], sm, sq);
        end
    endtask

    task automatic apply_reset(input int ncycles);
        @(negedge clk);
        rst_n = 1'b0;
        x = 1'b0;
        #1;
        check({scen, " rst z_mealy ov1"}, 8'(z_mealy1), 8'd0);
        check({scen, " rst z_moore ov1"}, 8'(z_moore1), 8'd0);
        check({scen, " rst z_mealy ov0"}, 8'(z_mealy0), 8'd0);
        check({scen, " rst z_moore ov0"}, 8'(z_moore0), 8'd0);
        clear_model();
        repeat (ncycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] word;
        logic sm, sq, expm, prevhit;

        // Reset held 30 ns with x toggling; outputs must stay low throughout.
        scen = "reset";
        rst_n = 1'b0;
        x = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 x = ~x;
            #3;
            check("reset z_mealy ov1", 8'(z_mealy1), 8'd0);
            check("reset z_moore ov1", 8'(z_moore1), 8'd0);
            check("reset z_mealy ov0", 8'(z_mealy0), 8'd0);
            check("reset z_moore ov0", 8'(z_moore0), 8'd0);
            #1;
        end
        #2;
        rst_n = 1'b1;
        x = 1'b0;
        clear_model();
        #1;
        check("reset mealy state", 8'(dut1.u_mealy.state), 8'(M_IDLE));
        check("reset moore state", 8'(dut1.u_moore.state), 8'(S_IDLE));
        @(negedge clk);
        #1;
        check("post-release mealy state", 8'(dut1.u_mealy.state), 8'(M_IDLE));
        check("post-release moore state", 8'(dut1.u_moore.state), 8'(S_IDLE));

        // Two periods of 0x0C9092: overlap hits at 9, 12, 20, 23; non-overlap keeps 9 and 20.
        scen = "rotate";
        word = 24'h0C9092;
        prevhit = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int pos = 0; pos < 24; pos++) begin
                drive_bit(word[23 - pos], sm, sq);
                expm = (pos == 9 || pos == 12 || pos == 20 || pos == 23);
                check("rotate mealy position", 8'(sm), 8'(expm));
                check("rotate moore position", 8'(sq), 8'(prevhit));
                prevhit = expm;
            end
        end
        drive_bit(1'b1, sm, sq);
        check("rotate moore tail", 8'(sq), 8'(prevhit));
        check("rotate mealy count ov1", 8'(cnt_m1), 8'd8);
        check("rotate moore count ov1", 8'(cnt_q1), 8'd8);
        check("rotate mealy count ov0", 8'(cnt_m0), 8'd4);
        check("rotate moore count ov0", 8'(cnt_q0), 8'd4);

        // Back-to-back 10010010.
        scen = "b2b";
        apply_reset(2);
        drive_seq(32'b10010010, 8);
        drive_bit(1'b1, sm, sq);
        check("b2b mealy count ov1", 8'(cnt_m1), 8'd2);
        check("b2b first hit index", 8'(first_m1), 8'd4);
        check("b2b second hit index", 8'(last_m1), 8'd7);
        check("b2b moore count ov1", 8'(cnt_q1), 8'd2);
        check("b2b mealy count ov0", 8'(cnt_m0), 8'd1);
        check("b2b moore count ov0", 8'(cnt_q0), 8'd1);

        // Near-miss stream.
        scen = "nearmiss";
        apply_reset(1);
        drive_seq(32'b100010110011, 12);
        drive_bit(1'b0, sm, sq);
        check("nearmiss mealy count ov1", 8'(cnt_m1), 8'd0);
        check("nearmiss moore count ov1", 8'(cnt_q1), 8'd0);
        check("nearmiss mealy count ov0", 8'(cnt_m0), 8'd0);
        check("nearmiss moore count ov0", 8'(cnt_q0), 8'd0);

        // Reset after 1001 must discard history; a fresh 10010 is still found.
        scen = "midreset";
        apply_reset(1);
        drive_seq(32'b1001, 4);
        apply_reset(1);
        drive_bit(1'b0, sm, sq);
        check("midreset no hit after reset", 8'(sm), 8'd0);
        drive_seq(32'b10010, 5);
        drive_bit(1'b1, sm, sq);
        check("midreset mealy count ov1", 8'(cnt_m1), 8'd1);
        check("midreset moore count ov1", 8'(cnt_q1), 8'd1);
        check("midreset mealy count ov0", 8'(cnt_m0), 8'd1);
        check("midreset moore count ov0", 8'(cnt_q0), 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
